ibex_div_seq: RTL and testbench

IBEX_DIV_SEQ -- requirements
Module: ibex_div_seq

---
 rtl/ibex_pkg.sv | 31 +++
 rtl/ibex_div_seq.sv | 161 ++++++++++++++++
 tb/tb_ibex_div_seq.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/ibex_pkg.sv
// Shared Ibex types used by the sequential divider: multdiv operation codes,
// divider FSM states and small operation-decode helpers.
package ibex_pkg;

    typedef enum logic [1:0] {
        MD_OP_DIV  = 2'd0,
        MD_OP_DIVU = 2'd1,
        MD_OP_REM  = 2'd2,
        MD_OP_REMU = 2'd3
    } md_op_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ABS_A = 3'd1,
        ABS_B = 3'd2,
        ITER  = 3'd3,
        FIX   = 3'd4,
        DONE  = 3'd5
    } div_state_e;

    localparam int unsigned DIV_ITERS = 32;

    function automatic logic md_op_signed(input md_op_e op);
        return (op == MD_OP_DIV) || (op == MD_OP_REM);
    endfunction

    function automatic logic md_op_rem(input md_op_e op);
        return (op == MD_OP_REM) || (op == MD_OP_REMU);
    endfunction

endpackage

// File: rtl/ibex_div_seq.sv
// Sequential 32-bit restoring divider borrowing the ALU's shared adder.
// Optional macro IBEX_DIV_FAST_PATH_EN: divide-by-zero finishes straight from IDLE.
module ibex_div_seq
    import ibex_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        div_en_i,
    input  md_op_e      operator_i,
    input  logic [31:0] op_a_i,
    input  logic [31:0] op_b_i,
    output logic [32:0] alu_operand_a_o,
    output logic [32:0] alu_operand_b_o,
    output logic        multdiv_en_o,
    input  logic [33:0] alu_adder_ext_i,
    output logic        valid_o,
    output logic [31:0] result_o
);

    div_state_e  state_reg, state_next;
    logic [5:0]  cnt_reg;
    md_op_e      op_reg;
    logic [31:0] dividend_reg, divisor_reg;
    logic        a_neg_reg, b_neg_reg;
    logic [31:0] rem_reg, quot_reg, result_reg;

    logic [31:0] adder_res;
    logic        adder_carry;
    logic [31:0] rem_shifted;
    logic        q_bit;
    logic        is_rem;
    logic        fix_neg;
    logic [31:0] fix_val;
    logic        fast_zero;
    logic        unused_adder_lsb;

    assign adder_res        = alu_adder_ext_i[32:1];
    assign adder_carry      = alu_adder_ext_i[33];
    assign unused_adder_lsb = alu_adder_ext_i[0];

    // The bit shifted out of rem makes the partial remainder a 33-bit value
    // that always exceeds the divisor, so it forces a subtraction.
    assign rem_shifted = {rem_reg[30:0], quot_reg[31]};
    assign q_bit       = rem_reg[31] | adder_carry;

    assign is_rem  = md_op_rem(op_reg);
    assign fix_val = is_rem ? rem_reg : quot_reg;
    assign fix_neg = is_rem ? a_neg_reg
                            : ((a_neg_reg ^ b_neg_reg) && (divisor_reg != 32'd0));

`ifdef IBEX_DIV_FAST_PATH_EN
    assign fast_zero = (op_b_i == 32'd0);
`else
    assign fast_zero = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (div_en_i) state_next = fast_zero ? DONE : ABS_A;
            ABS_A:   state_next = ABS_B;
            ABS_B:   state_next = ITER;
            ITER:    if (cnt_reg == 6'(DIV_ITERS - 1)) state_next = FIX;
            FIX:     state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if ((state_reg != IDLE) && !div_en_i) begin
            state_next = IDLE;
        end
    end

    // x - y is presented as {x,1} + {~y,1}; negation is the x = 0 case.
    always_comb begin
        multdiv_en_o    = 1'b0;
        alu_operand_a_o = 33'd0;
        alu_operand_b_o = 33'd0;
        valid_o         = 1'b0;
        result_o        = 32'd0;
        case (state_reg)
            ABS_A: begin
                multdiv_en_o    = 1'b1;
                alu_operand_a_o = {32'd0, 1'b1};
                alu_operand_b_o = {~dividend_reg, 1'b1};
            end
            ABS_B: begin
                multdiv_en_o    = 1'b1;
                alu_operand_a_o = {32'd0, 1'b1};
                alu_operand_b_o = {~divisor_reg, 1'b1};
            end
            ITER: begin
                multdiv_en_o    = 1'b1;
                alu_operand_a_o = {rem_shifted, 1'b1};
                alu_operand_b_o = {~divisor_reg, 1'b1};
            end
            FIX: begin
                multdiv_en_o    = 1'b1;
                alu_operand_a_o = {32'd0, 1'b1};
                alu_operand_b_o = {~fix_val, 1'b1};
            end
            DONE: begin
                valid_o  = div_en_i;
                result_o = div_en_i ? result_reg : 32'd0;
            end
            default: begin
                multdiv_en_o = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_reg      <= 6'd0;
            op_reg       <= MD_OP_DIV;
            dividend_reg <= 32'd0;
            divisor_reg  <= 32'd0;
            a_neg_reg    <= 1'b0;
            b_neg_reg    <= 1'b0;
            rem_reg      <= 32'd0;
            quot_reg     <= 32'd0;
            result_reg   <= 32'd0;
        end else begin
            case (state_reg)
                IDLE: if (div_en_i) begin
                    op_reg       <= operator_i;
                    dividend_reg <= op_a_i;
                    divisor_reg  <= op_b_i;
                    a_neg_reg    <= md_op_signed(operator_i) & op_a_i[31];
                    b_neg_reg    <= md_op_signed(operator_i) & op_b_i[31];
                    cnt_reg      <= 6'd0;
                    // Only used by the zero-divisor fast path; FIX overwrites it otherwise.
                    result_reg   <= md_op_rem(operator_i) ? op_a_i : 32'hFFFF_FFFF;
                end
                ABS_A: if (a_neg_reg) dividend_reg <= adder_res;
                ABS_B: begin
                    if (b_neg_reg) divisor_reg <= adder_res;
                    rem_reg  <= 32'd0;
                    quot_reg <= dividend_reg;
                end
                ITER: begin
                    rem_reg  <= q_bit ? adder_res : rem_shifted;
                    quot_reg <= {quot_reg[30:0], q_bit};
                    cnt_reg  <= cnt_reg + 6'd1;
                end
                FIX: result_reg <= fix_neg ? adder_res : fix_val;
                default: begin
                    cnt_reg <= cnt_reg;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ibex_div_seq.sv
// Self-checking bench for ibex_div_seq: models the ALU adder, keeps a
// scoreboard of expected results and checks latency and adder ownership.
module tb_ibex_div_seq;
    import ibex_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        div_en_i = 1'b0;
    md_op_e      operator_i = MD_OP_DIVU;
    logic [31:0] op_a_i = 32'd0;
    logic [31:0] op_b_i = 32'd0;
    logic [32:0] alu_operand_a_o, alu_operand_b_o;
    logic        multdiv_en_o;
    logic [33:0] alu_adder_ext_i;
    logic        valid_o;
    logic [31:0] result_o;

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          en_cycles;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Full path: ABS_A + ABS_B + 32 ITER + FIX, all owning the adder.
    localparam int LAT_FULL = 35;
    // Fast path: DONE is the cycle right after the sampling edge.
    localparam int LAT_FAST = 0;

    always #5 clk_i = ~clk_i;

    assign alu_adder_ext_i = {1'b0, alu_operand_a_o} + {1'b0, alu_operand_b_o};

    ibex_div_seq dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .div_en_i        (div_en_i),
        .operator_i      (operator_i),
        .op_a_i          (op_a_i),
        .op_b_i          (op_b_i),
        .alu_operand_a_o (alu_operand_a_o),
        .alu_operand_b_o (alu_operand_b_o),
        .multdiv_en_o    (multdiv_en_o),
        .alu_adder_ext_i (alu_adder_ext_i),
        .valid_o         (valid_o),
        .result_o        (result_o)
    );

    task automatic check(input string tag, input logic [33:0] got, input logic [33:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_div(input md_op_e op, input logic [31:0] a, input logic [31:0] b);
        logic   sgn;
        logic   rem;
        longint sa, sb_, r;
        sgn = (op == MD_OP_DIV) || (op == MD_OP_REM);
        rem = (op == MD_OP_REM) || (op == MD_OP_REMU);
        if (b == 32'd0) return rem ? a : 32'hFFFF_FFFF;
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rem ? 32'd0 : 32'h8000_0000;
        if (sgn) begin
            sa  = longint'($signed(a));
            sb_ = longint'($signed(b));
        end else begin
            sa  = longint'({32'd0, a});
            sb_ = longint'({32'd0, b});
        end
        r = rem ? (sa % sb_) : (sa / sb_);
        return r[31:0];
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"},   34'(valid_o),         34'd0);
        check({tag, "_mden"},    34'(multdiv_en_o),    34'd0);
        check({tag, "_result"},  34'(result_o),        34'd0);
        check({tag, "_alu_a"},   34'(alu_operand_a_o), 34'd0);
        check({tag, "_alu_b"},   34'(alu_operand_b_o), 34'd0);
    endtask

    task automatic run_op(input md_op_e op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   lat, en_cycles;
        logic got;
        logic fast;
`ifdef IBEX_DIV_FAST_PATH_EN
        fast = (b == 32'd0);
`else
        fast = 1'b0;
`endif
        e.res       = ref_div(op, a, b);
        e.lat       = fast ? LAT_FAST : LAT_FULL;
        e.en_cycles = fast ? 0 : LAT_FULL;
        sb.push_back(e);

        @(negedge clk_i);
        div_en_i   = 1'b1;
        operator_i = op;
        op_a_i     = a;
        op_b_i     = b;
        @(posedge clk_i); #1;
        lat = 0; en_cycles = 0; got = 1'b0;
        while (!got && lat < 100) begin
            if (multdiv_en_o) en_cycles++;
            if (valid_o) begin
                got = 1'b1;
            end else begin
                @(posedge clk_i); #1;
                lat++;
            end
        end
        check("valid_seen", 34'(got), 34'd1);
        e = sb.pop_front();
        if (got) begin
            check($sformatf("%s_result", op.name()), 34'(result_o), 34'(e.res));
            check($sformatf("%s_latency", op.name()), 34'(lat), 34'(e.lat));
            check($sformatf("%s_mden_cycles", op.name()), 34'(en_cycles), 34'(e.en_cycles));
        end
        $display("op %s a=%h b=%h -> result %h latency %0d (expect %h)",
                 op.name(), a, b, result_o, lat, e.res);
        @(negedge clk_i);
        div_en_i = 1'b0;
        @(posedge clk_i); #1;
        check("valid_pulse_end", 34'(valid_o), 34'd0);
    endtask

    initial begin
        logic seen_valid;

        #12;
        check_idle_outputs("reset");
        @(negedge clk_i);
        rst_ni = 1'b1;

        run_op(MD_OP_DIVU, 32'd100, 32'd7);
        run_op(MD_OP_REMU, 32'd100, 32'd7);
        run_op(MD_OP_DIV,  32'hFFFF_FFF9, 32'd2);
        run_op(MD_OP_REM,  32'hFFFF_FFF9, 32'd2);
        run_op(MD_OP_DIV,  32'd7, 32'hFFFF_FFFE);
        run_op(MD_OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF);
        run_op(MD_OP_REM,  32'h8000_0000, 32'hFFFF_FFFF);
        run_op(MD_OP_DIVU, 32'd5, 32'd0);
        run_op(MD_OP_REM,  32'hFFFF_FFFB, 32'd0);
        run_op(MD_OP_DIV,  32'hFFFF_FFFB, 32'd0);
        run_op(MD_OP_REMU, 32'hDEAD_BEEF, 32'd0);

        // Abort: drop the request ten cycles after the sampling edge.
        @(negedge clk_i);
        div_en_i = 1'b1; operator_i = MD_OP_DIVU; op_a_i = 32'd1000; op_b_i = 32'd3;
        @(posedge clk_i);
        repeat (10) @(posedge clk_i);
        @(negedge clk_i);
        div_en_i = 1'b0;
        @(posedge clk_i); #1;
        check("abort_mden", 34'(multdiv_en_o), 34'd0);
        seen_valid = 1'b0;
        repeat (40) begin
            @(posedge clk_i); #1;
            if (valid_o) seen_valid = 1'b1;
        end
        check("abort_no_valid", 34'(seen_valid), 34'd0);
        $display("op abort after 10 cycles -> valid seen %0d", seen_valid);
        run_op(MD_OP_DIVU, 32'd9, 32'd3);

        // Asynchronous reset in the middle of an operation.
        @(negedge clk_i);
        div_en_i = 1'b1; operator_i = MD_OP_DIV; op_a_i = 32'hFFFF_0000; op_b_i = 32'd77;
        @(posedge clk_i);
        repeat (20) @(posedge clk_i);
        #3;
        rst_ni = 1'b0;
        #1;
        check_idle_outputs("midop_reset");
        $display("op reset at cycle 20 -> mden %0d valid %0d", multdiv_en_o, valid_o);
        div_en_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        run_op(MD_OP_DIVU, 32'hFFFF_FFFF, 32'd1);

        for (int i = 0; i < 8; i++) begin
            md_op_e      op;
            logic [31:0] a, b;
            op = md_op_e'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom >> $urandom_range(0, 31);
            run_op(op, a, b);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
